// File: rtl/serial_mag_comp_pkg.sv
// rtl/serial_mag_comp_pkg.sv - shared types, constants and sizing helpers for serial_mag_comp
package serial_mag_comp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // One-hot result encoding, ordered {gt, eq, lt}
   localparam logic [2:0] RES_GT = 3'b100;
   localparam logic [2:0] RES_EQ = 3'b010;
   localparam logic [2:0] RES_LT = 3'b001;

   localparam int DEF_DIGIT = 2;

   function automatic int calcNdig(input int width, input int digit);
      return width / digit;
   endfunction

   // Counter must hold NDIG itself, not just NDIG-1
   function automatic int calcCntW(input int ndig);
      return $clog2(ndig + 1);
   endfunction

endpackage

// File: rtl/cmp_slice.sv
// rtl/cmp_slice.sv - combinational DIGIT-bit unsigned magnitude comparator
module cmp_slice
   import serial_mag_comp_pkg::*;
#(
   parameter int DIGIT = DEF_DIGIT
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             slice_gt,
   output logic             slice_eq,
   output logic             slice_lt
);

   logic higherEq;

   // MSB-first priority chain: a bit decides only while all higher bits matched
   always_comb begin
      slice_gt = 1'b0;
      higherEq = 1'b1;
      for (int i = DIGIT - 1; i >= 0; i--) begin
         slice_gt = slice_gt | (higherEq & a[i] & ~b[i]);
         higherEq = higherEq & ~(a[i] ^ b[i]);
      end
      slice_eq = &(~(a ^ b));
      slice_lt = ~slice_gt & ~slice_eq;
   end

endmodule

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - multi-cycle MSB-first magnitude comparator with early exit
module serial_mag_comp
   import serial_mag_comp_pkg::*;
#(
   parameter  int WIDTH      = 16,
   parameter  int DIGIT      = 2,
   parameter  int EARLY_EXIT = 1,
   localparam int NDIG       = calcNdig(WIDTH, DIGIT),
   localparam int CNTW       = calcCntW(NDIG)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [CNTW-1:0]  cycles
);

   localparam bit              EARLY     = (EARLY_EXIT != 0);
   localparam logic [CNTW-1:0] LAST_IDX  = CNTW'(NDIG - 1);
   // Flipping the sign bit maps two's complement onto offset binary
   localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   state_t          state, stateNext;
   logic [WIDTH-1:0] opA, opB;
   logic [CNTW-1:0]  idx, cnt;
   logic             diffSeen, firstGt;
   logic             sliceGt, sliceEq, sliceLt;
   logic             scanDone;
   logic [2:0]       resCode;

   // Operands are shifted left each step, so the digit under test is always the top one
   cmp_slice #(.DIGIT(DIGIT)) uSlice (
      .a        (opA[WIDTH-1 -: DIGIT]),
      .b        (opB[WIDTH-1 -: DIGIT]),
      .slice_gt (sliceGt),
      .slice_eq (sliceEq),
      .slice_lt (sliceLt)
   );

   assign scanDone    = (EARLY && !sliceEq) || (idx == '0);
   assign start_ready = (state == IDLE);
   assign res_valid   = (state == DONE);

   // Result chosen at the end of the scan: a recorded first difference wins over the last digit
   always_comb begin
      resCode = RES_EQ;
      if (diffSeen)     resCode = firstGt ? RES_GT : RES_LT;
      else if (sliceGt) resCode = RES_GT;
      else if (sliceLt) resCode = RES_LT;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Next-state decode
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (start_valid) stateNext = SCAN;
         SCAN:    if (scanDone)    stateNext = DONE;
         DONE:    if (res_ready)   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Operand capture, digit stepping and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opA      <= '0;
         opB      <= '0;
         idx      <= '0;
         cnt      <= '0;
         diffSeen <= 1'b0;
         firstGt  <= 1'b0;
         gt       <= 1'b0;
         eq       <= 1'b0;
         lt       <= 1'b0;
         cycles   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  opA      <= signed_mode ? (a ^ SIGN_MASK) : a;
                  opB      <= signed_mode ? (b ^ SIGN_MASK) : b;
                  idx      <= LAST_IDX;
                  cnt      <= '0;
                  diffSeen <= 1'b0;
                  firstGt  <= 1'b0;
               end
            end
            SCAN: begin
               cnt <= cnt + 1'b1;
               idx <= idx - 1'b1;
               opA <= opA << DIGIT;
               opB <= opB << DIGIT;
               if (!sliceEq && !diffSeen) begin
                  diffSeen <= 1'b1;
                  firstGt  <= sliceGt;
               end
               if (scanDone) begin
                  {gt, eq, lt} <= resCode;
                  cycles       <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/serial_mag_comp.md
# serial_mag_comp

Parametrised, multi-cycle magnitude comparator with mode select. It compares two WIDTH-bit operands MSB-first, DIGIT bits per clock, and stops early at the first differing digit. It returns one-hot greater/equal/less flags and the number of digits examined, over a valid/ready handshake on both sides. It replaces the fixed 2-bit combinational comparator in datapaths where operand width varies and area matters more than latency.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits compared per cycle; NDIG = WIDTH/DIGIT.
- EARLY_EXIT, 1, 1 = finish at first differing digit; 0 = always scan all NDIG digits.
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  request carries valid operands.
- start_ready  out  1  block accepts a request; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- gt  out  1  A > B.
- eq  out  1  A == B.
- lt  out  1  A < B.
- cycles  out  $clog2(NDIG+1)  digits examined, range 1..NDIG.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&start_ready, register a, b and signed_mode. Set idx=NDIG-1 and cnt=0, then go to SCAN.
  - Signed mode: invert the MSB of both captured operands (offset binary), so the scan is always unsigned.
- SCAN: each cycle compare digit idx of A and B through the slice, then cnt+=1.
  - Digits differ and EARLY_EXIT=1: register gt/lt from the slice, go to DONE.
  - Digits differ and EARLY_EXIT=0: record the first difference only. Later digits never overwrite it.
  - idx==0: finish. If no difference was recorded, eq=1. Go to DONE.
  - Otherwise idx-=1.
- DONE:
  - res_valid=1. gt/eq/lt/cycles are held stable.
  - On res_ready, go to IDLE on the next edge.
- Result rule: when res_valid=1, exactly one of gt/eq/lt is 1.
- start_valid outside IDLE is ignored, and no request is queued. Input changes after capture have no effect.
- Reset in any state, including mid-SCAN: the operation is abandoned and no result is produced.

## Timing
- Reset values: state=IDLE, start_ready=1, res_valid=0, gt=eq=lt=0, cycles=0. Internal operand and index registers are cleared.
- Capture edge E0. Result registers and res_valid rise at edge E0+n, where n = cycles.
- n range:
  - EARLY_EXIT=1: n is 1..NDIG.
  - EARLY_EXIT=0: n = NDIG always.
- res_valid with res_ready already high: res_valid lasts one cycle, and start_ready returns the following cycle.
- Minimum request-to-request spacing: n+2 cycles. There is no overlap.
- Outputs are registered. start_ready is decoded combinationally from state only.
- Flags and cycles keep their last values after leaving DONE until the next result. Consumers must qualify them with res_valid.

## Structure
- Shared package serial_mag_comp_pkg holds:
  - State enum (IDLE/SCAN/DONE, 2-bit).
  - Result encoding constants (GT/EQ/LT one-hot).
  - The NDIG and counter-width calculation functions.
- Sub-module cmp_slice: combinational DIGIT-bit comparator, outputs slice_gt and slice_eq.
  - Equality: per-bit XNOR, AND-reduced.
  - Greater-than: MSB-first priority chain a_i & ~b_i gated by the higher bits being equal.
  - slice_lt = ~slice_gt & ~slice_eq.
  - One instance only.

## Test plan
- WIDTH=2, DIGIT=1, unsigned, all 16 (a,b) pairs: flags match a>b, a==b and a<b; cycles=1 when a[1]!=b[1], else 2.
- WIDTH=16, DIGIT=2, a=16'h8000, b=16'h7FFF:
  - unsigned gives gt=1, cycles=1.
  - signed gives lt=1, cycles=1.
- a=b=16'h1234: eq=1, cycles=8, res_valid rises 8 edges after capture. a=16'h0001, b=16'h0000: gt=1, cycles=8.
- EARLY_EXIT=0, a=16'h8000, b=16'h0000: gt=1, cycles=8; the equal later digits do not clear gt.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid.
  - Flags stay stable and start_ready stays 0.
  - A start_valid pulse in that window is ignored.
  - Release res_ready: IDLE on the next edge.
- Assert rst during SCAN, cycle 3 of 8: res_valid=0 immediately (asynchronously), start_ready=1. The next request, a=16'h00FF, b=16'h0100, returns lt=1, cycles=4.
